multicycle_alu: RTL and testbench



---
 rtl/alu_ops_pkg.sv | 24 ++
 rtl/multicycle_alu_if.sv | 24 ++
 rtl/shift_add_multiplier.sv | 45 ++++
 rtl/multicycle_alu.sv | 112 +++++++++++
 tb/tb_multicycle_alu.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ops_pkg.sv
// Shared op-code map, FSM state encoding and flag reset values for the
// multi-cycle execute stage and the ALU control decoder.
package alu_ops_pkg;

  localparam logic [3:0] OP_AND      = 4'b0000;
  localparam logic [3:0] OP_OR       = 4'b0001;
  localparam logic [3:0] OP_NOR      = 4'b0010;
  localparam logic [3:0] OP_ADD      = 4'b0011;
  localparam logic [3:0] OP_SUB      = 4'b0100;
  localparam logic [3:0] OP_INC      = 4'b0101;
  localparam logic [3:0] OP_MULTPLUS = 4'b0110;
  localparam logic [3:0] OP_MOV      = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADDC = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  localparam logic ZERO_RST    = 1'b1;
  localparam logic ILLEGAL_RST = 1'b0;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control FSM (master) and the
// multi-cycle execute stage (slave).
interface multicycle_alu_if #(parameter int DATA_WIDTH = 32);
  logic                  Start;
  logic [3:0]            ALUOperation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [DATA_WIDTH-1:0] C;
  logic                  Ready;
  logic                  Done;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  IllegalOp;

  modport master (
    output Start, ALUOperation, A, B, C,
    input  Ready, Done, ALUResult, Zero, IllegalOp
  );

  modport slave (
    input  Start, ALUOperation, A, B, C,
    output Ready, Done, ALUResult, Zero, IllegalOp
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product add per step, product
// kept modulo 2^DATA_WIDTH. Raises i_last-qualified o_last on the final step.
module shift_add_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_mcand,
  input  logic [DATA_WIDTH-1:0] i_mplier,
  output logic [DATA_WIDTH-1:0] o_product,
  output logic                  o_last
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_product;
  logic [CNT_W-1:0]      r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_mcand   <= i_mcand;
      r_mplier  <= i_mplier;
      r_product <= '0;
      r_count   <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) r_product <= r_product + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CNT_W'(1);
    end
  end

  // Fixed latency: all DATA_WIDTH iterations run regardless of operand values.
  assign o_last    = (r_count == CNT_W'(DATA_WIDTH - 1));
  assign o_product = r_product;

endmodule

// File: rtl/multicycle_alu.sv
// Execute stage: single-cycle logic/arith ops plus a multi-cycle MULTPLUS
// (A*B + C), with a Start/Ready/Done handshake and registered result flags.
module multicycle_alu
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_alu_if.slave  bus
);

  alu_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_c;
  logic                  r_zero;
  logic                  r_illegal;
  logic                  r_done;
  logic                  r_ready;

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_mul_last;
  logic [DATA_WIDTH-1:0] w_product;
  logic [DATA_WIDTH-1:0] w_mul_sum;

  assign w_accept  = (r_state == ST_IDLE) && bus.Start;
  assign w_is_mul  = (bus.ALUOperation == OP_MULTPLUS);
  assign w_mul_sum = w_product + r_c;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (bus.ALUOperation)
      OP_AND:      w_result = bus.A & bus.B;
      OP_OR:       w_result = bus.A | bus.B;
      OP_NOR:      w_result = ~(bus.A | bus.B);
      OP_ADD:      w_result = bus.A + bus.B;
      OP_SUB:      w_result = bus.A - bus.B;
      OP_INC:      w_result = bus.A + DATA_WIDTH'(1);
      OP_MULTPLUS: w_result = '0;
      OP_MOV:      w_result = bus.B;
      default:     w_illegal = 1'b1;
    endcase
  end

  shift_add_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (w_accept && w_is_mul),
    .i_step    (r_state == ST_MUL),
    .i_mcand   (bus.A),
    .i_mplier  (bus.B),
    .o_product (w_product),
    .o_last    (w_mul_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_result  <= '0;
      r_c       <= '0;
      r_zero    <= ZERO_RST;
      r_illegal <= ILLEGAL_RST;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_is_mul) begin
              r_c     <= bus.C;
              r_state <= ST_MUL;
            end else begin
              r_result  <= w_result;
              r_zero    <= (w_result == '0);
              r_illegal <= w_illegal;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_last) r_state <= ST_ADDC;
        end
        ST_ADDC: begin
          r_result  <= w_mul_sum;
          r_zero    <= (w_mul_sum == '0);
          r_illegal <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.Done      = r_done;
  assign bus.ALUResult = r_result;
  assign bus.Zero      = r_zero;
  assign bus.IllegalOp = r_illegal;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu: single-cycle ops, MULTPLUS timing,
// busy-Start rejection, reset mid-multiply and illegal op handling.
module tb_multicycle_alu;
  localparam int DW = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  multicycle_alu_if #(.DATA_WIDTH(DW)) bus ();

  multicycle_alu #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits for Ready, issues one request, returns edges from accept to Done
  // and whether Ready was ever seen high while waiting.
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] c,
                        output int lat, output logic ready_seen);
    int n;
    n = 0;
    while (!bus.Ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.Start = 1'b1;
    bus.ALUOperation = op;
    bus.A = a; bus.B = b; bus.C = c;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.A = '1; bus.B = '1; bus.C = '1;
    lat = 0;
    ready_seen = 1'b0;
    while (!bus.Done && lat < 100) begin
      if (bus.Ready) ready_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  typedef struct {
    string      tag;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic       zero;
    logic       ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    logic rdy;
    int ndone;
    logic [DW-1:0] res_at_done;

    n_checks = 0; n_errors = 0;
    bus.Start = 1'b0; bus.ALUOperation = 4'b0000;
    bus.A = '0; bus.B = '0; bus.C = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_result", bus.ALUResult, 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd1);
    chk("rst_illegal", 32'(bus.IllegalOp), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0011, 32'd5, 32'd7, 32'd0, lat, rdy);
    chk("add_lat", 32'(lat), 32'd0);
    chk("add_res", bus.ALUResult, 32'd12);
    chk("add_zero", 32'(bus.Zero), 32'd0);
    chk("add_ready_in_done", 32'(bus.Ready), 32'd0);
    @(posedge clk); #1;
    chk("add_done_pulse", 32'(bus.Done), 32'd0);
    chk("add_ready_back", 32'(bus.Ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_res", bus.ALUResult, 32'd12);

    vecs[0] = '{"sub_eq",  4'b0100, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0};
    vecs[1] = '{"inc_wrap",4'b0101, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[2] = '{"and",     4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0};
    vecs[3] = '{"or",      4'b0001, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1'b0};
    vecs[4] = '{"nor",     4'b0010, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5] = '{"sub_neg", 4'b0100, 32'h1,        32'h2,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6] = '{"illegal", 4'b1001, 32'h55,       32'h66,       32'h0,        1'b1, 1'b1};
    vecs[7] = '{"mov",     4'b0111, 32'h1,        32'hABCD,     32'hABCD,     1'b0, 1'b0};
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 32'd0, lat, rdy);
      chk({vecs[i].tag, "_lat"}, 32'(lat), 32'd0);
      chk({vecs[i].tag, "_res"}, bus.ALUResult, vecs[i].res);
      chk({vecs[i].tag, "_zero"}, 32'(bus.Zero), 32'(vecs[i].zero));
      chk({vecs[i].tag, "_ill"}, 32'(bus.IllegalOp), 32'(vecs[i].ill));
    end

    run_op(4'b0110, 32'd1000, 32'd3000, 32'd7, lat, rdy);
    chk("mul_lat", 32'(lat), 32'(DW + 1));
    chk("mul_ready_low", 32'(rdy), 32'd0);
    chk("mul_res", bus.ALUResult, 32'd3000007);
    chk("mul_zero", 32'(bus.Zero), 32'd0);

    run_op(4'b0110, 32'h10000, 32'h10000, 32'd5, lat, rdy);
    chk("mul_ovf_lat", 32'(lat), 32'(DW + 1));
    chk("mul_ovf_res", bus.ALUResult, 32'd5);

    // Busy: ADD requests during the multiply must be dropped.
    @(posedge clk); #1;
    bus.Start = 1'b1; bus.ALUOperation = 4'b0110;
    bus.A = 32'd12; bus.B = 32'd11; bus.C = 32'd100;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    ndone = 0;
    res_at_done = '0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 5 || i == 20) begin
        bus.Start = 1'b1; bus.ALUOperation = 4'b0011;
        bus.A = 32'd1; bus.B = 32'd1;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.Done) begin
        ndone++;
        res_at_done = bus.ALUResult;
      end
    end
    bus.Start = 1'b0;
    chk("busy_done_count", 32'(ndone), 32'd1);
    chk("busy_res", res_at_done, 32'd232);

    // Reset at iteration 10 of a multiply.
    bus.Start = 1'b1; bus.ALUOperation = 4'b0110;
    bus.A = 32'd9; bus.B = 32'd9; bus.C = 32'd9;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.Ready), 32'd1);
    chk("midrst_result", bus.ALUResult, 32'd0);
    chk("midrst_zero", 32'(bus.Zero), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.Done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    run_op(4'b0011, 32'd100, 32'd23, 32'd0, lat, rdy);
    chk("post_rst_add_lat", 32'(lat), 32'd0);
    chk("post_rst_add_res", bus.ALUResult, 32'd123);

    // Back-to-back: next request in the IDLE cycle right after DONE.
    @(posedge clk); #1;
    chk("b2b_ready", 32'(bus.Ready), 32'd1);
    run_op(4'b0111, 32'd0, 32'h77, 32'd0, lat, rdy);
    chk("b2b_lat", 32'(lat), 32'd0);
    chk("b2b_res", bus.ALUResult, 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
